apb_completer_regs: RTL and testbench
=====================================

APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 32, APB address width; DATA_WIDTH, default 32, APB data width; NUM_REGS, default 8, register count including the status register; WAIT_STATES, default 0, extra ACCESS cycles before PREADY; BASE_ADDR, default 0, byte address of register 0.
REQ-002 PCLK  input  1  sole clock; all logic is updated on its rising edge.
REQ-003 PRESETn  input  1  reset, asynchronous assert, active-low.
REQ-004 PSEL  input  1  completer select from the bridge.
REQ-005 PENABLE  input  1  ACCESS-phase indicator.
REQ-006 PWRITE  input  1  1 = write, 0 = read.
REQ-007 PADDR  input  ADDR_WIDTH  byte address.
REQ-008 PWDATA  input  DATA_WIDTH  write data.
REQ-009 PRDATA  output  DATA_WIDTH  read data.
REQ-010 PREADY  output  1  transfer completion.
REQ-011 PSLVERR  output  1  transfer error; valid only when PREADY=1.
REQ-012 cfg_regs  output  NUM_REGS*DATA_WIDTH  flattened R/W registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 status_in  input  DATA_WIDTH  read-only value returned for register NUM_REGS-1.
REQ-014 wr_strobe  output  NUM_REGS  one-cycle pulse per register on a successful write.

Function
REQ-015 FSM states SHALL be IDLE and ACCESS; the wait counter SHALL be $clog2(WAIT_STATES+1) bits wide, minimum 1 bit.
REQ-016 IDLE -> ACCESS on PSEL=1 with PENABLE=0; on the same edge latch PADDR, PWRITE and PWDATA, and load the counter with WAIT_STATES.
REQ-017 In IDLE, PSEL=1 with PENABLE=1 (no SETUP) SHALL be ignored: no latch, PREADY stays 0.
REQ-018 In ACCESS with PENABLE=1 and counter nonzero: decrement the counter; PREADY=0.
REQ-019 In ACCESS with PENABLE=1 and counter=0: PREADY=1 combinationally; next state is IDLE.
REQ-020 A back-to-back SETUP on the cycle after completion SHALL be accepted from IDLE without a bubble.
REQ-021 In ACCESS, PSEL=0 SHALL abort the transfer: return to IDLE with no register update.
REQ-022 Decode: idx = (addr-BASE_ADDR)>>2.
REQ-023 Decode: the address is valid iff addr>=BASE_ADDR, addr[1:0]=0 and idx<NUM_REGS.
REQ-024 Write commit SHALL occur on the PREADY=1 edge only, into register idx, for a valid idx<NUM_REGS-1.
REQ-025 A write commit SHALL pulse wr_strobe[idx] for exactly the cycle after the commit edge.
REQ-026 PSLVERR=1 with PREADY=1 for an invalid address or a write to idx=NUM_REGS-1; no register changes.
REQ-027 PRDATA SHALL equal register idx (status_in for idx=NUM_REGS-1) when PREADY=1 on a valid read, and 0 otherwise.
REQ-028 PSLVERR and PRDATA SHALL be 0 whenever PREADY=0.
REQ-029 PREADY SHALL be 0 in IDLE.
REQ-030 cfg_regs SHALL be register outputs, with no combinational path from the APB inputs.

Reset
REQ-031 PRESETn=0 SHALL immediately force: state IDLE; counter 0; all R/W registers 0; PREADY, PSLVERR, PRDATA and wr_strobe 0.
REQ-032 Reset asserted mid-ACCESS SHALL discard the pending write; no strobe after deassertion.
REQ-033 After deassertion the first SETUP SHALL be accepted on the first rising edge.

Verification
REQ-034 WAIT_STATES=0: write 0xDEADBEEF to addr 0x04, then read 0x04 -> PREADY on the second cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0, wr_strobe[1] one pulse.
REQ-035 WAIT_STATES=3: write to 0x08 -> PREADY low for 3 ACCESS cycles, high on the 4th; cfg_regs reg2 updates only after the 4th.
REQ-036 Error cases -> PREADY=1, PSLVERR=1, no register change, PRDATA=0: write to 0x1C (status reg, NUM_REGS=8); read 0x20 (out of range); write 0x05 (misaligned).
REQ-037 status_in=0x12345678, read 0x1C -> PRDATA=0x12345678, PSLVERR=0.
REQ-038 Back-to-back writes 0x00 then 0x0C with no idle cycle -> both committed, wr_strobe[0] then wr_strobe[3] on consecutive completions.
REQ-039 PRESETn pulsed low during ACCESS of a write to 0x10 -> reg4 stays 0, no wr_strobe, next transfer completes normally.

Source files
------------

// File: rtl/apb_completer_regs.sv
// apb_completer_regs: APB completer exposing R/W config registers plus one read-only status register
module apb_completer_regs #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS = 8,
    parameter int WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
    input  logic [DATA_WIDTH-1:0]          status_in,
    output logic [NUM_REGS-1:0]            wr_strobe
);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int LAST = NUM_REGS - 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     strobe_q, strobe_d;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    valid, ro_hit, wr_en;
    logic [DATA_WIDTH-1:0]   rd_val;

    // Decode the latched address; the top slot reads back status_in, not a register
    always_comb begin
        idx = (addr_q - BASE_ADDR) >> 2;
        valid = (addr_q >= BASE_ADDR) && (addr_q[1:0] == 2'b00) && (idx < ADDR_WIDTH'(NUM_REGS));
        ro_hit = idx == ADDR_WIDTH'(LAST);
        rd_val = ro_hit ? status_in : '0;
        for (int i = 0; i < LAST; i++)
            if (idx == ADDR_WIDTH'(i)) rd_val = regs_q[i];
    end

    assign PREADY    = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == '0);
    assign wr_en     = PREADY && write_q && valid && !ro_hit;
    assign PSLVERR   = PREADY && (!valid || (write_q && ro_hit));
    assign PRDATA    = (PREADY && !write_q && valid) ? rd_val : '0;
    assign wr_strobe = strobe_q;

    // Transfer sequencing: capture on SETUP, count down wait states, leave on completion or abort
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        if (state_q == IDLE && PSEL && !PENABLE) begin
            state_d = ACCESS;
            cnt_d   = CW'(WAIT_STATES);
            addr_d  = PADDR;
            write_d = PWRITE;
            wdata_d = PWDATA;
        end else if (state_q == ACCESS && (!PSEL || PREADY)) begin
            state_d = IDLE;
        end else if (state_q == ACCESS && PENABLE && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Register bank update and the matching one-cycle write strobe
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            strobe_d[i] = wr_en && (idx == ADDR_WIDTH'(i));
            regs_d[i]   = strobe_d[i] ? wdata_q : regs_q[i];
        end
    end

    // All state flops, cleared immediately by reset so a pending write is dropped
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strobe_q <= '0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            regs_q   <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
endmodule

// File: tb/tb_apb_completer_regs.sv
// tb_apb_completer_regs: transaction-level model check of two completers (0 and 3 wait states)
module tb_apb_completer_regs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        psel[2], penable[2], pwrite[2], pready[2], pslverr[2];
    logic [31:0] paddr[2], pwdata[2], status[2], prdata[2];
    logic [255:0] cfg[2];
    logic [7:0]  strobe[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        apb_completer_regs #(.WAIT_STATES(g * 3)) u_dut (
            .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[g]), .PENABLE(penable[g]),
            .PWRITE(pwrite[g]), .PADDR(paddr[g]), .PWDATA(pwdata[g]), .PRDATA(prdata[g]),
            .PREADY(pready[g]), .PSLVERR(pslverr[g]), .cfg_regs(cfg[g]),
            .status_in(status[g]), .wr_strobe(strobe[g])
        );
    end

    logic [31:0] mregs[2][8];
    logic        exp_ready[2], exp_err[2], pend_wr[2];
    logic [31:0] exp_rdata[2], pend_data[2];
    logic [7:0]  exp_strobe[2], nxt_strobe[2];
    int          pend_idx[2];
    int          total = 0;
    int          bad = 0;
    logic [31:0] got_rd[2];
    logic        got_err[2];
    int          stb_cnt[2][8];
    int          wait_cnt[2];
    logic        rst_seen;

    task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    function automatic logic [255:0] flat(input int d);
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = mregs[d][i];
        return f;
    endfunction

    // Per-cycle comparison against the model, plus observation logs for literal checks
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("pready%0d", d), 256'(pready[d]), 256'(exp_ready[d]));
            chk($sformatf("pslverr%0d", d), 256'(pslverr[d]), 256'(exp_err[d]));
            chk($sformatf("prdata%0d", d), 256'(prdata[d]), 256'(exp_rdata[d]));
            chk($sformatf("wr_strobe%0d", d), 256'(strobe[d]), 256'(exp_strobe[d]));
            chk($sformatf("cfg_regs%0d", d), cfg[d], flat(d));
            if (pready[d]) begin
                got_rd[d] = prdata[d];
                got_err[d] = pslverr[d];
            end
            if (psel[d] && penable[d] && !pready[d]) wait_cnt[d]++;
            for (int i = 0; i < 8; i++) if (strobe[d][i]) stb_cnt[d][i]++;
        end
    end

    task automatic set_idle(input int d);
        psel[d] = 0; penable[d] = 0;
        exp_ready[d] = 0; exp_err[d] = 0; exp_rdata[d] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pend_wr[d]) mregs[d][pend_idx[d]] = pend_data[d];
            pend_wr[d] = 0;
            exp_strobe[d] = nxt_strobe[d];
            nxt_strobe[d] = '0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mregs[d][i] = '0;
            pend_wr[d] = 0; nxt_strobe[d] = '0; exp_strobe[d] = '0;
            set_idle(d);
        end
    endtask

    // One complete APB transfer; the model predicts the completion cycle from the address rules
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int idx;
        logic ok;
        psel[d] = 1; penable[d] = 0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        exp_ready[d] = 0; exp_err[d] = 0; exp_rdata[d] = '0;
        wait_cnt[d] = 0;
        tick();
        penable[d] = 1;
        repeat (d * 3) tick();
        idx = int'(addr >> 2);
        ok = (addr[1:0] == 2'b00) && (addr < 32);
        exp_ready[d] = 1;
        exp_err[d] = !ok || (wr && idx == 7);
        exp_rdata[d] = (!wr && ok) ? ((idx == 7) ? status[d] : mregs[d][idx]) : '0;
        if (wr && !exp_err[d]) begin
            pend_wr[d] = 1; pend_idx[d] = idx; pend_data[d] = data;
            nxt_strobe[d] = 8'(1 << idx);
        end
        tick();
        set_idle(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pwrite[d] = 0; paddr[d] = '0; pwdata[d] = '0; status[d] = '0;
            wait_cnt[d] = 0; got_rd[d] = '0; got_err[d] = 0;
            for (int i = 0; i < 8; i++) stb_cnt[d][i] = 0;
        end
        model_reset();
        tick();
        tick();
        chk("reset_cfg0", cfg[0], 256'(0));
        chk("reset_ready1", 256'(pready[1]), 256'(0));
        rst_n = 1;
        xfer(0, 1, 32'h04, 32'hDEADBEEF);
        chk("w04_ready_latency", 256'(wait_cnt[0]), 256'(0));
        xfer(0, 0, 32'h04, 32'h0);
        chk("r04_data", 256'(got_rd[0]), 256'(32'hDEADBEEF));
        chk("r04_err", 256'(got_err[0]), 256'(0));
        chk("w04_strobe_once", 256'(stb_cnt[0][1]), 256'(1));

        xfer(1, 1, 32'h08, 32'hA5A50002);
        chk("w08_wait_cycles", 256'(wait_cnt[1]), 256'(3));
        chk("w08_reg2", 256'(cfg[1][95:64]), 256'(32'hA5A50002));

        status[0] = 32'h12345678;
        xfer(0, 1, 32'h1C, 32'hFFFFFFFF);
        chk("w1c_err", 256'(got_err[0]), 256'(1));
        chk("w1c_rd", 256'(got_rd[0]), 256'(0));
        xfer(0, 0, 32'h20, 32'h0);
        chk("r20_err", 256'(got_err[0]), 256'(1));
        xfer(0, 1, 32'h05, 32'h55555555);
        chk("w05_err", 256'(got_err[0]), 256'(1));
        chk("err_cfg_kept", cfg[0], 256'({32'hDEADBEEF, 32'h0}));
        xfer(0, 0, 32'h1C, 32'h0);
        chk("r1c_status", 256'(got_rd[0]), 256'(32'h12345678));
        chk("r1c_err", 256'(got_err[0]), 256'(0));

        xfer(0, 1, 32'h00, 32'h11111111);
        xfer(0, 1, 32'h0C, 32'h33333333);
        tick();
        chk("b2b_strobe0", 256'(stb_cnt[0][0]), 256'(1));
        chk("b2b_strobe3", 256'(stb_cnt[0][3]), 256'(1));
        chk("b2b_reg3", 256'(cfg[0][127:96]), 256'(32'h33333333));
        xfer(1, 1, 32'h00, 32'hCAFE0000);
        xfer(1, 0, 32'h08, 32'h0);
        chk("b2b_ws_read", 256'(got_rd[1]), 256'(32'hA5A50002));

        psel[0] = 1; penable[0] = 1; pwrite[0] = 1; paddr[0] = 32'h08; pwdata[0] = 32'h77777777;
        repeat (3) tick();
        set_idle(0);
        tick();
        chk("no_setup_reg2", 256'(cfg[0][95:64]), 256'(0));

        psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 32'h0C; pwdata[1] = 32'h99999999;
        tick();
        penable[1] = 1;
        tick();
        psel[1] = 0;
        tick();
        set_idle(1);
        xfer(1, 0, 32'h0C, 32'h0);
        chk("abort_reg3", 256'(got_rd[1]), 256'(0));

        psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 32'h10; pwdata[1] = 32'h44444444;
        tick();
        penable[1] = 1;
        tick();
        #2;
        rst_n = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1;
        xfer(1, 0, 32'h10, 32'h0);
        chk("rst_reg4", 256'(got_rd[1]), 256'(0));
        chk("rst_no_strobe", 256'(stb_cnt[1][4]), 256'(0));
        xfer(1, 1, 32'h10, 32'h44);
        tick();
        chk("post_rst_reg4", 256'(cfg[1][159:128]), 256'(32'h44));
        chk("post_rst_strobe", 256'(stb_cnt[1][4]), 256'(1));
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
